// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner: walks rows through an external decoder, synchronizes the
// active-low columns, debounces whole-frame results and reports presses on valid/ready.
module keypad_matrix_scanner #(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 2,
    parameter int SETTLE   = 15,
    parameter int DEBOUNCE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         scan_en,
    output logic [ROW_BITS-1:0]          row_index,
    output logic                         row_enable,
    input  logic [(2**COL_BITS)-1:0]     col_n,
    output logic [ROW_BITS+COL_BITS-1:0] key_code,
    output logic                         key_valid,
    input  logic                         key_ready,
    output logic                         overrun,
    input  logic                         overrun_clr
);
    localparam int ROWS   = 2**ROW_BITS;
    localparam int COLS   = 2**COL_BITS;
    localparam int CODE_W = ROW_BITS + COL_BITS;
    localparam int CNT_W  = $clog2(SETTLE + 1);
    localparam int DEB_W  = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [DEB_W-1:0]    DEB_MAX     = DEB_W'(DEBOUNCE);
    localparam logic [ROW_BITS-1:0] LAST_ROW    = ROW_BITS'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FRAME_END
    } state_t;

    state_t              state_q;
    logic [ROW_BITS-1:0] rowIndex_q;
    logic                rowEnable_q;
    logic [CNT_W-1:0]    settleCnt_q;
    logic [COLS-1:0]     sync1_q;
    logic [COLS-1:0]     sync2_q;
    logic                frameValid_q;
    logic [CODE_W-1:0]   frameCode_q;
    logic                candValid_q;
    logic [CODE_W-1:0]   candCode_q;
    logic [DEB_W-1:0]    debCnt_q;
    logic [DEB_W-1:0]    debCnt_d;
    logic                keyValid_q;
    logic                keyValid_d;
    logic [CODE_W-1:0]   keyCode_q;
    logic [CODE_W-1:0]   keyCode_d;
    logic                overrun_q;
    logic                overrun_d;

    logic                colHit;
    logic [COL_BITS-1:0] colIdx;
    logic                sameResult;
    logic                pressEvent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= col_n;
            sync2_q <= sync1_q;
        end
    end

    // Scanning downwards leaves the lowest pressed column as the winner.
    always_comb begin
        colHit = 1'b0;
        colIdx = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!sync2_q[c]) begin
                colHit = 1'b1;
                colIdx = COL_BITS'(c);
            end
        end
    end

    assign sameResult = (frameValid_q == candValid_q) &&
                        (!frameValid_q || (frameCode_q == candCode_q));
    assign debCnt_d   = !sameResult              ? DEB_W'(1) :
                        (debCnt_q == DEB_MAX)    ? debCnt_q  :
                                                   debCnt_q + 1'b1;
    assign pressEvent = (state_q == ST_FRAME_END) && scan_en && frameValid_q &&
                        (debCnt_d == DEB_MAX) && !(sameResult && (debCnt_q == DEB_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rowIndex_q   <= '0;
            rowEnable_q  <= 1'b0;
            settleCnt_q  <= '0;
            frameValid_q <= 1'b0;
            frameCode_q  <= '0;
            candValid_q  <= 1'b0;
            candCode_q   <= '0;
            debCnt_q     <= '0;
        end else if (!scan_en) begin
            state_q      <= ST_IDLE;
            rowIndex_q   <= '0;
            rowEnable_q  <= 1'b0;
            settleCnt_q  <= '0;
            frameValid_q <= 1'b0;
            frameCode_q  <= '0;
            candValid_q  <= 1'b0;
            candCode_q   <= '0;
            debCnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q     <= ST_SETTLE;
                    rowEnable_q <= 1'b1;
                    rowIndex_q  <= '0;
                    settleCnt_q <= '0;
                end
                ST_SETTLE: begin
                    if (settleCnt_q == SETTLE_LAST) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        settleCnt_q <= settleCnt_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (!frameValid_q && colHit) begin
                        frameValid_q <= 1'b1;
                        frameCode_q  <= {rowIndex_q, colIdx};
                    end
                    if (rowIndex_q != LAST_ROW) begin
                        rowIndex_q  <= rowIndex_q + 1'b1;
                        settleCnt_q <= '0;
                        state_q     <= ST_SETTLE;
                    end else begin
                        state_q <= ST_FRAME_END;
                    end
                end
                ST_FRAME_END: begin
                    candValid_q  <= frameValid_q;
                    candCode_q   <= frameCode_q;
                    debCnt_q     <= debCnt_d;
                    frameValid_q <= 1'b0;
                    frameCode_q  <= '0;
                    rowIndex_q   <= '0;
                    settleCnt_q  <= '0;
                    state_q      <= ST_SETTLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A press can reload the output in the same cycle the old one is taken.
    always_comb begin
        keyValid_d = keyValid_q;
        keyCode_d  = keyCode_q;
        overrun_d  = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (keyValid_q && key_ready) begin
            keyValid_d = 1'b0;
        end
        if (pressEvent) begin
            if (!keyValid_q || key_ready) begin
                keyValid_d = 1'b1;
                keyCode_d  = frameCode_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyValid_q <= 1'b0;
            keyCode_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            keyValid_q <= keyValid_d;
            keyCode_q  <= keyCode_d;
            overrun_q  <= overrun_d;
        end
    end

    assign row_index  = rowIndex_q;
    assign row_enable = rowEnable_q;
    assign key_code   = keyCode_q;
    assign key_valid  = keyValid_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural 4x4 key matrix;
// cycle numbers count posedges after scanning starts (frame = 65 cycles).
module tb_keypad_matrix_scanner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en;
    logic [1:0] row_index;
    logic       row_enable;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overrun;
    logic       overrun_clr;

    logic [15:0] keyMap;
    logic [15:0] frameKeys [0:15];
    int          checks = 0;
    int          errors = 0;
    int          evCount;
    int          evHigh;
    int          evCycle [0:7];
    logic [3:0]  evCode [0:7];

    keypad_matrix_scanner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .row_index   (row_index),
        .row_enable  (row_enable),
        .col_n       (col_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Pressed switches on the enabled row pull their column low.
    assign col_n = ~(row_enable ? keyMap[{row_index, 2'b00} +: 4] : 4'b0000);

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        @(negedge clk);
        rst_n       = 1'b0;
        scan_en     = 1'b0;
        overrun_clr = 1'b0;
        keyMap      = frameKeys[0];
        @(negedge clk);
        rst_n   = 1'b1;
        scan_en = 1'b1;
    endtask

    task automatic runFrames(input int nCycles);
        logic prevValid;
        prevValid = 1'b0;
        evCount   = 0;
        evHigh    = 0;
        for (int n = 1; n <= nCycles; n++) begin
            stepCycle();
            if (key_valid === 1'b1) begin
                evHigh++;
                if (!prevValid) begin
                    if (evCount < 8) begin
                        evCycle[evCount] = n;
                        evCode[evCount]  = key_code;
                    end
                    evCount++;
                end
            end
            prevValid = (key_valid === 1'b1);
            if ((n % 65 == 0) && (n / 65 < 16)) keyMap = frameKeys[n / 65];
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        scan_en     = 1'b1;
        key_ready   = 1'b0;
        overrun_clr = 1'b0;
        keyMap      = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (row_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_row_enable got %0b want 0", row_enable); end
        checks++; if (row_index !== 2'd0) begin errors++; $display("[TB] FAIL reset_row_index got %0d want 0", row_index); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_valid got %0b want 0", key_valid); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_key_code got %0d want 0", key_code); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_row_scan();
        int         chkN [0:7];
        logic [1:0] chkRow [0:7];
        int         highs;
        chkN   = '{1, 16, 17, 32, 33, 49, 65, 66};
        chkRow = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
        for (int f = 0; f < 16; f++) frameKeys[f] = 16'h0000;
        key_ready = 1'b1;
        restart();
        #1;
        checks++; if (row_enable !== 1'b0) begin errors++; $display("[TB] FAIL idle_row_enable got %0b want 0", row_enable); end
        highs = 0;
        for (int n = 1; n <= 130; n++) begin
            stepCycle();
            if (key_valid !== 1'b0) highs++;
            for (int k = 0; k < 8; k++) begin
                if (chkN[k] == n) begin
                    checks++;
                    if (row_index !== chkRow[k]) begin
                        errors++;
                        $display("[TB] FAIL row_index_cycle%0d got %0d want %0d", n, row_index, chkRow[k]);
                    end
                    checks++;
                    if (row_enable !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL row_enable_cycle%0d got %0b want 1", n, row_enable);
                    end
                end
            end
        end
        checks++; if (highs != 0) begin errors++; $display("[TB] FAIL no_key_valid got %0d high cycles want 0", highs); end
    endtask

    task automatic test_single_key();
        for (int f = 0; f < 16; f++) frameKeys[f] = 16'h0200;
        key_ready = 1'b1;
        restart();
        runFrames(395);
        checks++; if (evCount != 1) begin errors++; $display("[TB] FAIL single_event_count got %0d want 1", evCount); end
        checks++; if (evHigh != 1) begin errors++; $display("[TB] FAIL single_valid_cycles got %0d want 1", evHigh); end
        checks++; if (evCycle[0] != 261) begin errors++; $display("[TB] FAIL single_event_cycle got %0d want 261", evCycle[0]); end
        checks++; if (evCode[0] !== 4'b1001) begin errors++; $display("[TB] FAIL single_event_code got %b want 1001", evCode[0]); end
    endtask

    task automatic test_bounce();
        for (int f = 0; f < 16; f++) frameKeys[f] = 16'h0200;
        frameKeys[1] = 16'h0000;
        frameKeys[3] = 16'h0000;
        key_ready = 1'b1;
        restart();
        runFrames(650);
        checks++; if (evCount != 1) begin errors++; $display("[TB] FAIL bounce_event_count got %0d want 1", evCount); end
        checks++; if (evCycle[0] != 521) begin errors++; $display("[TB] FAIL bounce_event_cycle got %0d want 521", evCycle[0]); end
        checks++; if (evCode[0] !== 4'b1001) begin errors++; $display("[TB] FAIL bounce_event_code got %b want 1001", evCode[0]); end
    endtask

    task automatic test_priority();
        for (int f = 0; f < 16; f++) frameKeys[f] = (f < 5) ? 16'h1080 : (f < 7) ? 16'h0000 : 16'h1000;
        key_ready = 1'b1;
        restart();
        runFrames(780);
        checks++; if (evCount != 2) begin errors++; $display("[TB] FAIL prio_event_count got %0d want 2", evCount); end
        checks++; if (evCycle[0] != 261) begin errors++; $display("[TB] FAIL prio_first_cycle got %0d want 261", evCycle[0]); end
        checks++; if (evCode[0] !== 4'b0111) begin errors++; $display("[TB] FAIL prio_first_code got %b want 0111", evCode[0]); end
        checks++; if (evCycle[1] != 716) begin errors++; $display("[TB] FAIL prio_second_cycle got %0d want 716", evCycle[1]); end
        checks++; if (evCode[1] !== 4'b1100) begin errors++; $display("[TB] FAIL prio_second_code got %b want 1100", evCode[1]); end
    endtask

    task automatic test_overrun();
        for (int f = 0; f < 16; f++) frameKeys[f] = (f < 4) ? 16'h0001 : (f < 6) ? 16'h0000 : 16'h0020;
        key_ready = 1'b0;
        restart();
        runFrames(650);
        checks++; if (evCount != 1) begin errors++; $display("[TB] FAIL ovr_event_count got %0d want 1", evCount); end
        checks++; if (evCycle[0] != 261) begin errors++; $display("[TB] FAIL ovr_event_cycle got %0d want 261", evCycle[0]); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_before_drop got %0b want 0", overrun); end
        stepCycle();
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set got %0b want 1", overrun); end
        checks++; if (key_code !== 4'b0000) begin errors++; $display("[TB] FAIL ovr_code_held got %b want 0000", key_code); end
        checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid_held got %0b want 1", key_valid); end
        key_ready = 1'b1;
        stepCycle();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_drain_valid got %0b want 0", key_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky got %0b want 1", overrun); end
        overrun_clr = 1'b1;
        stepCycle();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear got %0b want 0", overrun); end
    endtask

    task automatic test_reset_mid();
        for (int f = 0; f < 16; f++) frameKeys[f] = 16'h0020;
        key_ready = 1'b0;
        restart();
        runFrames(270);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pending got %0b want 1", key_valid); end
        checks++; if (key_code !== 4'b0101) begin errors++; $display("[TB] FAIL rstmid_code got %b want 0101", key_code); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %0b want 0", key_valid); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("[TB] FAIL rstmid_key_code got %b want 0000", key_code); end
        checks++; if (row_enable !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_row_enable got %0b want 0", row_enable); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_scan_en_drop();
        for (int f = 0; f < 16; f++) frameKeys[f] = 16'h0020;
        key_ready = 1'b0;
        restart();
        runFrames(270);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL drop_pending got %0b want 1", key_valid); end
        scan_en = 1'b0;
        stepCycle();
        checks++; if (row_enable !== 1'b0) begin errors++; $display("[TB] FAIL drop_row_enable got %0b want 0", row_enable); end
        checks++; if (row_index !== 2'd0) begin errors++; $display("[TB] FAIL drop_row_index got %0d want 0", row_index); end
        checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL drop_valid_kept got %0b want 1", key_valid); end
        checks++; if (key_code !== 4'b0101) begin errors++; $display("[TB] FAIL drop_code_kept got %b want 0101", key_code); end
        key_ready = 1'b1;
        stepCycle();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_accept got %0b want 0", key_valid); end
        scan_en = 1'b1;
        runFrames(300);
        checks++; if (evCount != 1) begin errors++; $display("[TB] FAIL resume_event_count got %0d want 1", evCount); end
        checks++; if (evCycle[0] != 261) begin errors++; $display("[TB] FAIL resume_event_cycle got %0d want 261", evCycle[0]); end
        checks++; if (evCode[0] !== 4'b0101) begin errors++; $display("[TB] FAIL resume_event_code got %b want 0101", evCode[0]); end
    endtask

    initial begin
        test_reset();
        test_row_scan();
        test_single_key();
        test_bounce();
        test_priority();
        test_overrun();
        test_reset_mid();
        test_scan_en_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Scans a 2^ROW_BITS x 2^COL_BITS switch matrix and emits debounced key-press events on a valid/ready interface.
- Directly upstream of the parameterized binary decoder: row_index/row_enable drive the decoder's in/enable, and the decoder's one-cold outputs drive the matrix rows.
- Column lines return to this block active-low.

Parameters:
- ROW_BITS, 2, row address width; ROWS = 2^ROW_BITS.
- COL_BITS, 2, column index width; COLS = 2^COL_BITS.
- SETTLE, 15, cycles a row is held before sampling; must be >= 2 to cover synchronizer latency.
- DEBOUNCE, 4, consecutive identical frame results required for an event; must be >= 1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- scan_en  in  1  scanning enable.
- row_index  out  ROW_BITS  row address to decoder in.
- row_enable  out  1  decoder enable.
- col_n  in  COLS  asynchronous column lines, low = pressed on the selected row.
- key_code  out  ROW_BITS+COL_BITS  {row, col} of the reported key.
- key_valid  out  1  event pending.
- key_ready  in  1  consumer accepts the event.
- overrun  out  1  sticky: an event was dropped.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset, asynchronous, while rst_n = 0:
  - row_index = 0, row_enable = 0, key_code = 0, key_valid = 0, overrun = 0.
  - Synchronizer flops = all ones (no key).
  - Settle counter = 0, candidate = NONE, debounce count = 0, frame result = NONE.
- Synchronizer: col_n passes through 2 flops; only the synchronized value is used.
- FSM states:
  - IDLE: row_enable = 0, row_index = 0.
    - Move to SETTLE when scan_en = 1.
  - SETTLE: row_enable = 1; count SETTLE cycles on the current row.
    - Move to SAMPLE when the count reaches SETTLE.
  - SAMPLE: one cycle.
    - If frame result is NONE and any synchronized column is low, record {row_index, lowest low column}.
    - If row_index < ROWS-1: increment row_index, clear the counter, go to SETTLE.
    - Else: go to FRAME_END.
  - FRAME_END: one cycle.
    - Run the debounce update, reset frame result to NONE, set row_index = 0, go to SETTLE.
- Row timing and priority:
  - Each row occupies SETTLE+1 cycles.
  - One frame = ROWS*(SETTLE+1)+1 cycles; 65 with defaults.
  - With multiple keys pressed, the lowest code wins (lowest row first, then lowest column).
- Debounce update, with frame result r:
  - If r == candidate: count = min(count+1, DEBOUNCE).
  - Else: candidate = r, count = 1.
  - A press event fires when the new count == DEBOUNCE, the previous state was not (same candidate, count == DEBOUNCE), and candidate != NONE.
  - A held key therefore reports once. Re-reporting the same key requires an intervening different result (e.g. NONE).
  - Switching directly from key A to a stable key B reports B.
- Output handshake:
  - Event with key_valid = 0: next cycle key_code = candidate, key_valid = 1.
  - key_code is held stable while key_valid = 1.
  - The event is transferred on a cycle where key_valid and key_ready are both 1. key_valid drops next cycle unless a new event arrives in that same cycle, in which case the new code loads and key_valid stays 1.
  - Event while key_valid = 1 and key_ready = 0: the event is dropped, key_code is unchanged, and overrun is set.
  - overrun_clr clears overrun; a set occurring in the same cycle wins.
- scan_en low mid-frame:
  - Go to IDLE next cycle; the partial frame is discarded.
  - Candidate/count are cleared to NONE/0.
  - A pending key_valid/key_code is retained and the handshake stays live.
- Reset mid-operation: all state returns to reset values immediately; a pending event is lost.

Test Plan (defaults; frame = 65 cycles):
- Reset release, scan_en = 1 -> row_enable = 1 after IDLE exit; row_index steps 0,1,2,3 at 16-cycle intervals; key_valid stays 0 with no keys pressed.
- col_n[1] low only while row_index == 2, held 6 frames, key_ready = 1 -> exactly one key_valid pulse, key_code = 4'b1001, asserted the cycle after the 4th frame's FRAME_END.
- Same key bouncing (present/absent in alternate frames for 3 frames), then stable -> exactly one event, code 4'b1001, no event during the bounce.
- Row1/col3 and row3/col0 pressed together -> code 4'b0111; release all, press row3/col0 alone -> second event 4'b1100.
- key_ready = 0: event A (4'b0000), then release and stable key B (4'b0101) -> overrun = 1, key_code stays 4'b0000; key_ready = 1 drains A; overrun_clr pulse -> overrun = 0.
- rst_n low mid-SETTLE with key_valid = 1 -> key_valid, key_code, row_enable, overrun all 0 in the same cycle without a clock edge; scan_en dropped mid-frame -> row_enable = 0 next cycle, pending event still accepted.
